spi_slave_if: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 25 ++
 rtl/spi_slave_if_if.sv | 24 ++
 rtl/spi_miso_serializer.sv | 48 ++++
 rtl/spi_slave_if.sv | 129 ++++++++++++
 tb/tb_spi_slave_if.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI-slave front end.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StReadAdd,
        StReadData
    } state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned CMD_W      = DEF_DATA_W + 2;

    // Command word is two opcode bits on top of the RAM data width.
    function automatic int unsigned cmd_width(input int unsigned data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pins plus the RAM-facing command/read-data handshake of the slave front end.
interface spi_slave_if_if
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_W = 8
);
    logic                           SS_n;
    logic                           MOSI;
    logic                           MISO;
    logic [cmd_width(DATA_W)-1:0]   rx_data;
    logic                           rx_valid;
    logic [DATA_W-1:0]              tx_data;
    logic                           tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_miso_serializer.sv
// Loads one RAM read word and shifts it out MSB first on MISO, one bit per clk.
module spi_miso_serializer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              miso_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int unsigned CntW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            shreg_d = load_data_i;
            cnt_d   = CntW'(DATA_W);
        end else if (busy_o) begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    // High while the final bit is on the wire.
    assign done_o = (cnt_q == CntW'(1));
    assign miso_o = busy_o & shreg_q[DATA_W-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI command words for the RAM and
// serialises RAM read data back on MISO.
module spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_slave_if_if.slave        bus
);
    localparam int unsigned     CmdW    = cmd_width(DATA_W);
    localparam int unsigned     CntW    = $clog2(CmdW + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(CmdW - 1);
    localparam logic [CntW-1:0] AllBits = CntW'(CmdW);

    state_e          state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CmdW-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rd_addr_seen_q, rd_addr_seen_d;
    logic            sent_q, sent_d;
    logic            shift_en;
    logic            ser_load, ser_clear, ser_busy, ser_done, ser_miso;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        sent_d         = sent_q;
        shift_en       = 1'b0;
        ser_load       = 1'b0;
        ser_clear      = 1'b0;

        if (bus.SS_n && state_q != StIdle) begin
            // Deselect aborts whatever is in flight; the read flag survives for a retry.
            state_d   = StIdle;
            bit_cnt_d = '0;
            sent_d    = 1'b0;
            ser_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    bit_cnt_d = '0;
                    sent_d    = 1'b0;
                    if (!bus.SS_n) begin
                        state_d = StChkCmd;
                    end
                end
                StChkCmd: begin
                    shift_en = 1'b1;
                    if (!bus.MOSI) begin
                        state_d = StWrite;
                    end else if (rd_addr_seen_q) begin
                        state_d = StReadData;
                    end else begin
                        state_d = StReadAdd;
                    end
                end
                StWrite, StReadAdd, StReadData: begin
                    if (bit_cnt_q != AllBits) begin
                        shift_en = 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            rx_valid_d = 1'b1;
                            if (state_q == StReadAdd) begin
                                rd_addr_seen_d = 1'b1;
                            end
                        end
                    end else if (state_q == StReadData) begin
                        // Wait for RAM data once the strobe cycle is over; one load per frame.
                        if (!sent_q && !ser_busy && !rx_valid_q && bus.tx_valid) begin
                            ser_load = 1'b1;
                        end
                        if (ser_done) begin
                            sent_d         = 1'b1;
                            rd_addr_seen_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (shift_en) begin
            rx_data_d = {rx_data_q[CmdW-2:0], bus.MOSI};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            sent_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            sent_q         <= sent_d;
        end
    end

    spi_miso_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (ser_clear),
        .load_i      (ser_load),
        .load_data_i (bus.tx_data),
        .miso_o      (ser_miso),
        .busy_o      (ser_busy),
        .done_o      (ser_done)
    );

    assign bus.MISO     = ser_miso;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if against a frame-level model of the SPI protocol.
module tb_spi_slave_if;
    import spi_slave_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic seen_m   = 1'b0;

    spi_slave_if_if #(.DATA_W(8)) bus ();

    spi_slave_if #(
        .DATA_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample just after the edge.
    task automatic step(input logic ss, input logic mosi, input logic tv, input logic [7:0] td);
        bus.SS_n     = ss;
        bus.MOSI     = mosi;
        bus.tx_valid = tv;
        bus.tx_data  = td;
        @(posedge clk);
        #1;
    endtask

    // Write / read-address frame, or any frame cut short after nbits bits.
    task automatic rx_frame(input logic [9:0] word, input int nbits, input int hold);
        step(1'b0, 1'($urandom), 1'b0, 8'h00);
        check_eq("miso_sel", bus.MISO, 0);
        for (int b = 0; b < nbits; b++) begin
            step(1'b0, word[9-b], 1'b0, 8'h00);
            check_eq("rx_valid_bit", bus.rx_valid, 32'(b == 9));
            check_eq("miso_rx", bus.MISO, 0);
        end
        if (nbits == 10) begin
            check_eq("rx_data", bus.rx_data, word);
            if (word[9]) seen_m = 1'b1;
            for (int h = 0; h < hold; h++) begin
                step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
                check_eq("rx_valid_hold", bus.rx_valid, 0);
                check_eq("miso_hold", bus.MISO, 0);
                check_eq("rx_data_hold", bus.rx_data, word);
            end
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("rx_valid_end", bus.rx_valid, 0);
        check_eq("miso_end", bus.MISO, 0);
    endtask

    // Read-data frame; requires seen_m. nmiso < 8 deselects after that many MISO bits.
    task automatic rd_frame(input logic [9:0] word, input int lat, input logic [7:0] rdata,
                            input int nmiso);
        step(1'b0, 1'($urandom), 1'b0, 8'h00);
        for (int b = 0; b < 10; b++) begin
            step(1'b0, word[9-b], 1'b0, 8'h00);
            check_eq("rd_rx_valid", bus.rx_valid, 32'(b == 9));
            check_eq("rd_miso_rx", bus.MISO, 0);
        end
        check_eq("rd_rx_data", bus.rx_data, word);
        step(1'b0, 1'($urandom), 1'b0, 8'($urandom));
        for (int w = 1; w < lat; w++) begin
            check_eq("miso_wait", bus.MISO, 0);
            step(1'b0, 1'($urandom), 1'b0, 8'($urandom));
        end
        step(1'b0, 1'($urandom), 1'b1, rdata);
        for (int k = 0; k < 8; k++) begin
            check_eq("miso_bit", bus.MISO, 32'(rdata[7-k]));
            if (k + 1 == nmiso && nmiso < 8) begin
                step(1'b1, 1'b0, 1'b0, 8'h00);
                check_eq("miso_abort", bus.MISO, 0);
                return;
            end
            step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
        end
        check_eq("miso_after", bus.MISO, 0);
        seen_m = 1'b0;
        step(1'b0, 1'($urandom), 1'b1, 8'hFF);
        check_eq("miso_no_reload", bus.MISO, 0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("miso_rd_end", bus.MISO, 0);
    endtask

    task automatic reset_mid(input logic [9:0] word, input int nbits);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int b = 0; b < nbits; b++) step(1'b0, word[9-b], 1'b0, 8'h00);
        rst_n = 1'b0;
        for (int r = 0; r < 2; r++) begin
            step(1'b0, 1'($urandom), 1'b0, 8'h00);
            check_eq("rst_rx_valid", bus.rx_valid, 0);
            check_eq("rst_miso", bus.MISO, 0);
            check_eq("rst_rx_data", bus.rx_data, 0);
        end
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        seen_m = 1'b0;
    endtask

    initial begin
        logic [9:0] word;
        int         r;
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("init_rx_valid", bus.rx_valid, 0);
        check_eq("init_miso", bus.MISO, 0);
        check_eq("init_rx_data", bus.rx_data, 0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Reset must clear the read-address flag as well as abort the frame.
        rx_frame(10'h2A5, 10, 1);
        reset_mid(10'h0F0, 5);
        rx_frame(10'h3C3, 10, 3);
        rd_frame({OP_RD_DATA, 8'h00}, 1, 8'h81, 8);

        rx_frame({OP_WR_ADDR, 8'hA5}, 10, 2);
        rx_frame({OP_WR_DATA, 8'h3C}, 10, 3);

        rx_frame({OP_RD_ADDR, 8'hA5}, 10, 1);
        rd_frame({OP_RD_DATA, 8'($urandom)}, 1, 8'hC3, 8);

        rx_frame(10'h1FF, 6, 0);
        rx_frame(10'h0A5, 10, 1);
        rx_frame(10'h155, 9, 0);
        rx_frame(10'h0C3, 10, 1);

        rx_frame(10'h2A5, 10, 1);
        rd_frame(10'h3A5, 2, 8'hA7, 3);
        rd_frame(10'h35A, 3, 8'h5A, 8);

        for (int n = 0; n < 40; n++) begin
            word = 10'($urandom);
            r    = int'($urandom_range(0, 9));
            if (r == 0) begin
                rx_frame(word, int'($urandom_range(0, 9)), 0);
            end else if (word[9] && seen_m) begin
                rd_frame(word, int'($urandom_range(1, 4)), 8'($urandom),
                         (r == 1) ? int'($urandom_range(1, 7)) : 8);
            end else begin
                rx_frame(word, 10, 1 + int'($urandom_range(0, 2)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
